ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares one parameterized dual-port RAM (separate write and read ports) among NUM_REQ requesters.
//  Write and read requests are arbitrated independently, each round-robin, so up to 1 write + 1 read per cycle.
//  Read data returns tagged to its requester after RD_LATENCY cycles. Sits between client blocks and the RAM instance.
// PARAMETERS
//  NUM_REQ     4     number of requesters (2..8)
//  DATA_WIDTH  8     RAM word width
//  ADDR_WIDTH  10    RAM address width
//  RD_LATENCY  1     RAM read latency in cycles (data_out valid RD_LATENCY clocks after read_enable), 1..4
// PORTS
//  clk           in   1                     clock, rising edge
//  rst           in   1                     asynchronous, active-low reset
//  req_valid     in   NUM_REQ               per-requester request valid
//  req_we        in   NUM_REQ               1=write, 0=read
//  req_addr      in   NUM_REQ*ADDR_WIDTH    flattened, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  req_wdata     in   NUM_REQ*DATA_WIDTH    flattened write data
//  req_ready     out  NUM_REQ               grant; request accepted when valid&ready
//  rsp_valid     out  NUM_REQ               one-cycle read-data strobe, one-hot
//  rsp_data      out  DATA_WIDTH            read data for the strobed requester
//  ram_write_addr / ram_write_enable / ram_data_in   out  ADDR_WIDTH / 1 / DATA_WIDTH   RAM write port
//  ram_read_addr  / ram_read_enable                  out  ADDR_WIDTH / 1                RAM read port
//  ram_data_out  in   DATA_WIDTH            RAM read data
// BEHAVIOUR
//  - Reset (rst=0): wr_ptr=rd_ptr=0, tag pipeline cleared, rsp_valid=0, rsp_data=0; all ram_* outputs and req_ready are 0 while in reset.
//  - Grant is combinational from registered pointers: write arbiter picks the first i starting at wr_ptr (wrapping) with req_valid[i]&req_we[i];
//    read arbiter likewise from rd_ptr with req_valid[i]&!req_we[i]. At most one write and one read grant per cycle.
//  - On a write grant to i: ram_write_enable=1, addr/data from requester i, same cycle; wr_ptr <= (i+1) mod NUM_REQ.
//  - On a read grant to i: ram_read_enable=1, ram_read_addr from i, same cycle; rd_ptr <= (i+1) mod NUM_REQ;
//    push {valid,i} into RD_LATENCY-deep tag shift register; when it emerges, rsp_valid[i]=1, rsp_data=ram_data_out (registered, so
//    rsp_valid asserts RD_LATENCY+1 cycles after the read handshake). Back-to-back reads pipelined, one per cycle, in order.
//  - Pointers move only on a grant; no grant -> pointer holds, ram_*_enable=0, addr/data outputs hold last value.
//  - Collision: if the selected read address equals the granted write address in the same cycle, the read is NOT granted (req_ready low)
//    and rd_ptr holds; it issues next cycle and returns the newly written data. Write has priority.
//  - Requesters must hold req_* stable until ready; dropping valid before grant is allowed (request withdrawn, no side effect).
//  - Pointer wrap: NUM_REQ-1 -> 0. Fairness: a continuously-requesting client is granted within NUM_REQ same-type grants.
//  - Reset asserted mid-operation: in-flight read tags are discarded, no rsp_valid after reset release for pre-reset reads.
// CONFIGURATION
//  RAM_ARB_STATS_EN defined: adds output grant_cnt [NUM_REQ*16], per-requester saturating 16-bit count of accepted requests (read+write),
//   cleared by reset, saturates at 16'hFFFF. Not defined: port and counters absent; all other behaviour identical.
// STRUCTURE
//  - Package ram_arb_pkg: req_idx_t (clog2 NUM_REQ), rd_tag_t struct {logic vld; req_idx_t idx;}, MAX_REQ=8 constant.
//  - Sub-module rr_arbiter (request vector + pointer in, one-hot grant + index + any out), instantiated twice (write, read).
//  - Top holds pointers, collision check, tag pipeline, response register, optional stats counters.
// TESTING
//  1 Reset: rst=0 with req_valid=4'hF -> req_ready=0, ram_*_enable=0, rsp_valid=0; release -> first write grant to req 0.
//  2 Single write then read: req1 writes 8'hAA @10, next cycle req1 reads @10 -> rsp_valid=4'b0010, rsp_data=8'hAA RD_LATENCY+1 cycles later.
//  3 Round-robin: all 4 hold write requests for 8 cycles -> grants 0,1,2,3,0,1,2,3; wr_ptr wraps 3->0.
//  4 Concurrent: req0 writes @5 and req2 reads @7 same cycle -> both granted; req2 reads @5 concurrently with write @5 -> read deferred 1 cycle, returns new data.
//  5 Pipelined reads: req0..3 read @0..3 (preloaded 8'h10..8'h13) on consecutive cycles -> rsp_valid one-hot 1,2,4,8 in order, data 10..13.
//  6 Reset mid-flight: assert rst the cycle after a read grant -> no rsp_valid after release; with RAM_ARB_STATS_EN, grant_cnt all 0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM port arbiter: requester index, read-tag record.
package ram_arb_pkg;
  // Index type is sized for the largest supported requester count so it can
  // live in a non-parameterized package.
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = $clog2(MAX_REQ);

  typedef logic [IDX_W-1:0] req_idx_t;

  typedef struct packed {
    logic     vld;
    req_idx_t idx;
  } rd_tag_t;

  // Round-robin successor: n-1 wraps to 0.
  function automatic req_idx_t next_idx(req_idx_t i, int n);
    return (int'(i) >= n - 1) ? '0 : i + 1'b1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  req_idx_t     ptr_i,
  output logic [N-1:0] gnt_o,
  output req_idx_t     idx_o,
  output logic         any_o
);

  // Scan offsets 0..N-1 from the pointer; the first hit wins. Constant loop
  // bounds keep every bit-select static.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!any_o && req_i[i] &&
            ((int'(ptr_i) + k == i) || (int'(ptr_i) + k == i + N))) begin
          gnt_o[i] = 1'b1;
          idx_o    = req_idx_t'(i);
          any_o    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one dual-port RAM among NUM_REQ clients: independent round-robin
// write and read arbiters, same-address write wins, tagged read returns.
// Optional feature macro: RAM_ARB_STATS_EN adds per-requester grant counters.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ADDR_WIDTH-1:0]         ram_write_addr,
  output logic                          ram_write_enable,
  output logic [DATA_WIDTH-1:0]         ram_data_in,
  output logic [ADDR_WIDTH-1:0]         ram_read_addr,
  output logic                          ram_read_enable,
  input  logic [DATA_WIDTH-1:0]         ram_data_out
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         grant_cnt
`endif
);

  req_idx_t                wr_ptr_q, rd_ptr_q;
  logic [NUM_REQ-1:0]      wr_gnt, rd_gnt;
  req_idx_t                wr_idx, rd_idx;
  logic                    wr_any, rd_any;
  logic [ADDR_WIDTH-1:0]   wr_addr_sel, rd_addr_sel;
  logic [DATA_WIDTH-1:0]   wr_data_sel;
  logic                    coll, rd_fire;
  logic [ADDR_WIDTH-1:0]   wa_q, ra_q;
  logic [DATA_WIDTH-1:0]   wd_q;
  rd_tag_t                 tag_q [RD_LATENCY];
  rd_tag_t                 tag_out;
  logic [NUM_REQ-1:0]      rsp_vld_d, rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_data_q;

  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .req_i (req_valid & req_we),
    .ptr_i (wr_ptr_q),
    .gnt_o (wr_gnt),
    .idx_o (wr_idx),
    .any_o (wr_any)
  );

  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .req_i (req_valid & ~req_we),
    .ptr_i (rd_ptr_q),
    .gnt_o (rd_gnt),
    .idx_o (rd_idx),
    .any_o (rd_any)
  );

  // One-hot AND-OR mux of the selected requesters' address/data.
  always_comb begin
    wr_addr_sel = '0;
    wr_data_sel = '0;
    rd_addr_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wr_gnt[i]) begin
        wr_addr_sel = wr_addr_sel | req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        wr_data_sel = wr_data_sel | req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
      if (rd_gnt[i]) rd_addr_sel = rd_addr_sel | req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Same-address read is held off a cycle so it observes the new write.
  assign coll    = wr_any && rd_any && (wr_addr_sel == rd_addr_sel);
  assign rd_fire = rd_any && !coll;

  // Everything the clients and RAM see is forced quiet while reset is low.
  assign req_ready        = rst ? (wr_gnt | (rd_fire ? rd_gnt : '0)) : '0;
  assign ram_write_enable = rst && wr_any;
  assign ram_read_enable  = rst && rd_fire;
  assign ram_write_addr   = !rst ? '0 : (wr_any  ? wr_addr_sel : wa_q);
  assign ram_data_in      = !rst ? '0 : (wr_any  ? wr_data_sel : wd_q);
  assign ram_read_addr    = !rst ? '0 : (rd_fire ? rd_addr_sel : ra_q);

  // Pointers advance past the winner; port values are remembered for idle cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wa_q     <= '0;
      wd_q     <= '0;
      ra_q     <= '0;
    end else begin
      if (wr_any) begin
        wr_ptr_q <= next_idx(wr_idx, NUM_REQ);
        wa_q     <= wr_addr_sel;
        wd_q     <= wr_data_sel;
      end
      if (rd_fire) begin
        rd_ptr_q <= next_idx(rd_idx, NUM_REQ);
        ra_q     <= rd_addr_sel;
      end
    end
  end

  // Tag shift register tracks which requester owns each in-flight read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < RD_LATENCY; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= '{vld: rd_fire, idx: rd_idx};
      for (int k = 1; k < RD_LATENCY; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign tag_out = tag_q[RD_LATENCY-1];

  // Decode the emerging tag into the one-hot response strobe.
  always_comb begin
    rsp_vld_d = '0;
    for (int i = 0; i < NUM_REQ; i++)
      rsp_vld_d[i] = tag_out.vld && (tag_out.idx == req_idx_t'(i));
  end

  // Response register: capture RAM data alongside the strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_vld_d;
      if (tag_out.vld) rsp_data_q <= ram_data_out;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

`ifdef RAM_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];

  // Saturating accepted-request counters, reads and writes combined.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (req_ready[i] && (cnt_q[i] != 16'hFFFF)) cnt_q[i] <= cnt_q[i] + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign grant_cnt[g*16 +: 16] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed table, hand sequences, random traffic
// against a cycle-level reference built from the arbitration rules.
module tb_ram_port_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int L  = 1;

  logic              clk, rst;
  logic [N-1:0]      req_valid, req_we, req_ready, rsp_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [DW-1:0]     rsp_data, ram_data_in, ram_data_out;
  logic [AW-1:0]     ram_write_addr, ram_read_addr;
  logic              ram_write_enable, ram_read_enable;
`ifdef RAM_ARB_STATS_EN
  logic [N*16-1:0]   grant_cnt;
`endif

  ram_port_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_write_addr(ram_write_addr), .ram_write_enable(ram_write_enable),
    .ram_data_in(ram_data_in), .ram_read_addr(ram_read_addr),
    .ram_read_enable(ram_read_enable), .ram_data_out(ram_data_out)
`ifdef RAM_ARB_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM with L-cycle registered read.
  logic [DW-1:0] ram [1024];
  logic [DW-1:0] rpipe [L];
  initial for (int i = 0; i < 1024; i++) ram[i] = '0;
  always @(posedge clk) begin
    if (ram_write_enable) ram[ram_write_addr] <= ram_data_in;
    if (ram_read_enable) rpipe[0] <= ram[ram_read_addr];
    for (int k = 1; k < L; k++) rpipe[k] <= rpipe[k-1];
  end
  assign ram_data_out = rpipe[L-1];

  int errors = 0;
  int checks = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model state.
  typedef struct { int due; int idx; logic [DW-1:0] d; } exp_t;
  exp_t          q[$];
  int            m_wp, m_rp, cyc;
  logic [DW-1:0] m_mem [1024];
  logic [AW-1:0] l_wa, l_ra;
  logic [DW-1:0] l_wd;
  initial for (int i = 0; i < 1024; i++) m_mem[i] = '0;

  function automatic logic [AW-1:0] ad(int i);
    return req_addr[i*AW +: AW];
  endfunction
  function automatic logic [DW-1:0] wd(int i);
    return req_wdata[i*DW +: DW];
  endfunction
  function automatic int pick(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_check();
    int w, r;
    logic [N-1:0] er, ev;
    exp_t e;
    if (!rst) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_we", ram_write_enable, 0);
      chk("rst_re", ram_read_enable, 0);
      chk("rst_waddr", ram_write_addr, 0);
      chk("rst_wdata", ram_data_in, 0);
      chk("rst_raddr", ram_read_addr, 0);
      chk("rst_rspv", rsp_valid, 0);
      chk("rst_rspd", rsp_data, 0);
      m_wp = 0; m_rp = 0; q.delete();
      l_wa = '0; l_ra = '0; l_wd = '0;
      cyc++;
      return;
    end
    w = pick(req_valid & req_we, m_wp);
    r = pick(req_valid & ~req_we, m_rp);
    if (w >= 0 && r >= 0 && ad(w) == ad(r)) r = -1;
    er = '0;
    if (w >= 0) begin er[w] = 1'b1; l_wa = ad(w); l_wd = wd(w); end
    if (r >= 0) begin er[r] = 1'b1; l_ra = ad(r); end
    chk("ready", req_ready, er);
    chk("wen", ram_write_enable, w >= 0);
    chk("ren", ram_read_enable, r >= 0);
    chk("waddr", ram_write_addr, l_wa);
    chk("wdata", ram_data_in, l_wd);
    chk("raddr", ram_read_addr, l_ra);
    ev = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      ev[e.idx] = 1'b1;
      chk("rsp_data", rsp_data, e.d);
    end
    chk("rsp_valid", rsp_valid, ev);
    if (r >= 0) begin
      q.push_back('{due: cyc + L + 1, idx: r, d: m_mem[ad(r)]});
      m_rp = (r + 1) % N;
    end
    if (w >= 0) begin
      m_mem[ad(w)] = wd(w);
      m_wp = (w + 1) % N;
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic drive(int i, bit v, bit we, int a, int d);
    req_valid[i] = v;
    req_we[i]    = we;
    req_addr[i*AW +: AW]  = AW'(a);
    req_wdata[i*DW +: DW] = DW'(d);
  endtask

  typedef struct {
    logic [N-1:0]    v, we;
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;
    logic [N-1:0]    er;
  } tv_t;
  tv_t tv [11];

  initial begin
    // Directed vectors, applied from the reset pointer state.
    for (int i = 0; i < 8; i++) begin
      tv[i].v  = 4'hF;
      tv[i].we = 4'hF;
      tv[i].a  = {10'd23, 10'd22, 10'd21, 10'd20};
      tv[i].d  = 32'hD3D2D1D0;
      tv[i].er = 4'b0001 << (i % 4);
    end
    tv[8]  = '{v: 4'b0101, we: 4'b0001, a: {10'd0, 10'd7, 10'd0, 10'd5}, d: 32'h00000033, er: 4'b0101};
    tv[9]  = '{v: 4'b0101, we: 4'b0001, a: {10'd0, 10'd5, 10'd0, 10'd5}, d: 32'h0000005A, er: 4'b0001};
    tv[10] = '{v: 4'b0100, we: 4'b0000, a: {10'd0, 10'd5, 10'd0, 10'd0}, d: 32'h00000000, er: 4'b0100};

    cyc = 0; m_wp = 0; m_rp = 0;
    rst = 1'b0;
    clr();
    req_valid = 4'hF; req_we = 4'hF;
    tick(); tick();
    chk("t1_ready", req_ready, 0);
    chk("t1_en", {ram_write_enable, ram_read_enable}, 0);
    chk("t1_rspv", rsp_valid, 0);
`ifdef RAM_ARB_STATS_EN
    chk("t1_cnt", grant_cnt, 0);
`endif
    rst = 1'b1;

    // Round-robin, concurrent read/write, collision deferral.
    for (int i = 0; i < 11; i++) begin
      req_valid = tv[i].v; req_we = tv[i].we; req_addr = tv[i].a; req_wdata = tv[i].d;
      #1;
      chk($sformatf("tbl_rdy[%0d]", i), req_ready, tv[i].er);
      tick();
    end
    clr();
    tick();
    chk("t4_defer_rspv", rsp_valid, 4'b0100);
    chk("t4_defer_rspd", rsp_data, 8'h5A);

    // Single write then read by requester 1.
    clr(); drive(1, 1, 1, 10, 8'hAA); #1;
    chk("t2_wr_rdy", req_ready, 4'b0010);
    tick();
    clr(); drive(1, 1, 0, 10, 0); #1;
    chk("t2_rd_rdy", req_ready, 4'b0010);
    tick();
    clr();
    chk("t2_early", rsp_valid, 0);
    tick();
    chk("t2_rspv", rsp_valid, 4'b0010);
    chk("t2_rspd", rsp_data, 8'hAA);

    // Pipelined reads from all requesters.
    for (int k = 0; k < 4; k++) begin
      clr(); drive(0, 1, 1, k, 8'h10 + k); tick();
    end
    for (int k = 0; k < 4; k++) begin
      clr(); drive(k, 1, 0, k, 0); tick();
      if (k >= 1) begin
        chk($sformatf("t5_rspv[%0d]", k - 1), rsp_valid, 4'b0001 << (k - 1));
        chk($sformatf("t5_rspd[%0d]", k - 1), rsp_data, 8'h10 + k - 1);
      end
    end
    clr(); tick();
    chk("t5_rspv[3]", rsp_valid, 4'b1000);
    chk("t5_rspd[3]", rsp_data, 8'h13);

    // Reset while a read is in flight.
    clr(); drive(3, 1, 0, 2, 0); tick();
    clr(); rst = 1'b0; #1;
    chk("t6_in_rst", rsp_valid, 0);
    tick(); tick();
`ifdef RAM_ARB_STATS_EN
    chk("t6_cnt", grant_cnt, 0);
`endif
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t6_after[%0d]", k), rsp_valid, 0);
    end

    // Random traffic with a small address space to provoke collisions.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        drive(i, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255));
      if (c == 200) rst = 1'b0;
      if (c == 203) rst = 1'b1;
      tick();
    end
    clr();
    for (int k = 0; k < L + 2; k++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
